stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Fetch/decode/dispatch controller for the stack machine.
- Reads instruction words from an asynchronous-read instruction memory and decodes them.
- Dispatches stack/memory transfers to the push/pop unit and arithmetic to the ALU unit, then waits for each unit's completion pulse.
- Handles jumps, halt and a completion timeout itself; the program counter and sequencing state live here.

Parameters:
- ADDR_LEN, 8, width of program counter, instruction address and operand address.
- DATA_LEN, 8, instruction/operand/stack word width (must be >= 4).
- TIMEOUT, 15, max WAIT cycles for a unit's fin before ERROR.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- start  in  1  begin execution at pc=0 (sampled in IDLE/HALT only)
- imem_addr  out  ADDR_LEN  combinational: pc in FETCH, pc+1 in OPND, else pc
- imem_data  in  DATA_LEN  instruction memory read data, valid same cycle
- stk_top  in  DATA_LEN  current top-of-stack value, used by JZ
- pp_en  out  1  one-cycle enable to push/pop unit
- pp_fin  in  1  push/pop unit completion pulse
- alu_en  out  1  one-cycle enable to ALU unit
- alu_fin  in  1  ALU completion pulse
- control_bus  out  4  opcode forwarded to units, registered
- addr_const  out  DATA_LEN  operand (constant or memory address), registered
- pc  out  ADDR_LEN  program counter
- busy  out  1  high in every state except IDLE, HALT, ERROR
- halted  out  1  high in HALT
- err  out  1  high in ERROR, sticky
- instr_cnt  out  16  retired-instruction counter, saturating at 16'hFFFF

Behaviour:
- Reset (async, rstn=0): state=IDLE; pc=0, control_bus=0, addr_const=0, pp_en=0, alu_en=0, busy=0, halted=0, err=0, instr_cnt=0.
- Reset mid-operation aborts immediately and drops en; the units are expected to be reset by the same rstn.
- Instruction opcode = imem_data[3:0].
- Opcode map:
  - 0 PUSHC, 1 PUSHM, 2 POPM: 2 words, go to the push/pop unit.
  - 4..7 ALU ops: 1 word, go to the ALU.
  - 8 JMP, 9 JZ: 2 words, handled internally.
  - 15 HALT: 1 word.
  - Any other opcode is illegal and goes to ERROR.
- States: IDLE, FETCH, DECODE, OPND, EXEC, WAIT, HALT, ERROR.
  - IDLE: start=1 -> pc<=0, instr_cnt<=0, FETCH.
  - FETCH: ir<=imem_data -> DECODE.
  - DECODE (per ir[3:0]):
    - 2-word opcodes -> OPND.
    - ALU -> EXEC.
    - HALT -> HALT, instr_cnt++.
    - Illegal -> ERROR.
  - OPND: opnd<=imem_data. JMP and JZ are 2 words.
    - JMP: pc<=opnd, instr_cnt++ -> FETCH.
    - JZ: pc<=(stk_top==0)?opnd:pc+2, instr_cnt++ -> FETCH.
    - Otherwise -> EXEC.
  - EXEC: control_bus<=ir[3:0]; addr_const<=opnd (0 for ALU ops); pulse pp_en (opcodes 0-2) or alu_en (4-7) for exactly one cycle; clear wait counter -> WAIT.
  - WAIT:
    - control_bus and addr_const are held stable.
    - Only the selected unit's fin is honoured; a fin from the other unit is ignored.
    - fin=1 -> pc<=pc+len (len 2 for 0-2, 1 for 4-7), instr_cnt++ -> FETCH.
    - Counter reaching TIMEOUT with no fin -> ERROR.
  - HALT: halted=1; start=1 -> restart as from IDLE.
  - ERROR: err=1, all enables 0; exit only via rstn. pc freezes at the faulting instruction.
- Boundaries:
  - pc and pc+1/pc+2 wrap modulo 2^ADDR_LEN.
  - fin arriving during EXEC (same cycle as en) is ignored.
  - start while busy is ignored.
  - The JZ stk_top sample is taken in the OPND cycle.
- Minimum latency per instruction:
  - ALU: 3 cycles plus unit latency.
  - Push/pop: 4 cycles plus unit latency.
  - JMP/JZ: 3 cycles.

Decomposition:
- Shared package (stack_pkg) holds:
  - opcode constants: OP_PUSHC=0, OP_PUSHM=1, OP_POPM=2, OP_ADD..OP_DIV=4..7, OP_JMP=8, OP_JZ=9, OP_HALT=15;
  - state encoding constants;
  - an instr_len(opcode) function returning 1 or 2.
- One sub-module, seq_decoder: combinational opcode -> {needs_operand, is_pp, is_alu, is_jump, is_halt, illegal}.

Test Plan:
- Program {00,05,00,07,04,0F}, both units fin 2 cycles after en:
  - pp_en pulses twice with addr_const 5 then 7, alu_en pulses once with control_bus=4;
  - ends halted=1, pc=5, instr_cnt=4.
- JZ taken vs not: {09,20} at pc=0.
  - stk_top=0 -> pc=0x20.
  - stk_top=3 -> pc=2.
  - No enable pulses in either case.
- Timeout: PUSHM with pp_fin never asserted -> err=1 exactly TIMEOUT cycles after WAIT entry, pc=0, pp_en low thereafter.
- Illegal opcode 0x0B at pc=3 -> ERROR on the DECODE cycle, err=1, no en pulse, instr_cnt unchanged.
- Stray alu_fin while waiting on the push/pop unit -> ignored; the later pp_fin advances pc by 2.
- rstn=0 mid-WAIT -> all outputs return to reset values asynchronously; start then re-runs from pc=0. Also check JMP to 0xFF followed by a 1-word ALU op wraps pc to 0x00.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack machine sequencer.
// Holds the opcode map, the sequencer state encoding and the
// instruction-length helper used to advance the program counter.
package stack_pkg;

    localparam logic [3:0] OP_PUSHC = 4'd0;
    localparam logic [3:0] OP_PUSHM = 4'd1;
    localparam logic [3:0] OP_POPM  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_JZ    = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StOpnd,
        StExec,
        StWait,
        StHalt,
        StError
    } seq_state_e;

    // Number of instruction words occupied by an opcode.
    function automatic logic [1:0] instr_len(input logic [3:0] op);
        if (op == OP_PUSHC || op == OP_PUSHM || op == OP_POPM ||
            op == OP_JMP || op == OP_JZ) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode classifier for the stack sequencer.
// Ports:
//   opcode        - instruction opcode (low nibble of the instruction word)
//   needs_operand - instruction has a second word (push/pop and jumps)
//   is_pp         - dispatched to the push/pop unit
//   is_alu        - dispatched to the ALU unit
//   is_jump       - JMP or JZ, handled inside the sequencer
//   is_halt       - HALT
//   illegal       - opcode not in the map
module seq_decoder
    import stack_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       needs_operand,
    output logic       is_pp,
    output logic       is_alu,
    output logic       is_jump,
    output logic       is_halt,
    output logic       illegal
);

    always_comb begin
        needs_operand = 1'b0;
        is_pp         = 1'b0;
        is_alu        = 1'b0;
        is_jump       = 1'b0;
        is_halt       = 1'b0;
        illegal       = 1'b0;
        case (opcode)
            OP_PUSHC, OP_PUSHM, OP_POPM: begin
                needs_operand = 1'b1;
                is_pp         = 1'b1;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                is_alu = 1'b1;
            end
            OP_JMP, OP_JZ: begin
                needs_operand = 1'b1;
                is_jump       = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Fetch/decode/dispatch controller for the stack machine.
// Fetches from an asynchronous-read instruction memory, dispatches push/pop
// and ALU work to the external units and waits for their fin pulse, and
// executes JMP/JZ/HALT itself. A unit that never answers within TIMEOUT
// cycles parks the sequencer in a sticky ERROR state.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   start                - begin execution at pc=0 (IDLE/HALT only)
//   imem_addr/imem_data  - instruction memory address / same-cycle read data
//   stk_top              - top of stack, tested by JZ
//   pp_en/pp_fin         - push/pop unit enable pulse / completion pulse
//   alu_en/alu_fin       - ALU unit enable pulse / completion pulse
//   control_bus          - opcode for the units (registered)
//   addr_const           - operand for the units (registered)
//   pc                   - program counter
//   busy/halted/err      - status flags
//   instr_cnt            - saturating retired-instruction count
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 8,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic [DATA_LEN-1:0] imem_data,
    input  logic [DATA_LEN-1:0] stk_top,
    output logic                pp_en,
    input  logic                pp_fin,
    output logic                alu_en,
    input  logic                alu_fin,
    output logic [3:0]          control_bus,
    output logic [DATA_LEN-1:0] addr_const,
    output logic [ADDR_LEN-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [15:0]         instr_cnt
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    seq_state_e          state_q, state_d;
    logic [3:0]          ir_q, ir_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [3:0]          cb_q, cb_d;
    logic [DATA_LEN-1:0] ac_q, ac_d;
    logic [15:0]         icnt_q, icnt_d, icnt_inc;
    logic [CntW-1:0]     wcnt_q, wcnt_d;

    logic needs_operand, is_pp, is_alu, is_jump, is_halt, illegal;

    seq_decoder u_dec (
        .opcode        (ir_q),
        .needs_operand (needs_operand),
        .is_pp         (is_pp),
        .is_alu        (is_alu),
        .is_jump       (is_jump),
        .is_halt       (is_halt),
        .illegal       (illegal)
    );

    assign icnt_inc = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        cb_d    = cb_q;
        ac_d    = ac_q;
        icnt_d  = icnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = '0;
                    icnt_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = imem_data[3:0];
                state_d = StDecode;
            end
            StDecode: begin
                if (illegal) begin
                    state_d = StError;
                end else if (is_halt) begin
                    icnt_d  = icnt_inc;
                    state_d = StHalt;
                end else if (needs_operand) begin
                    state_d = StOpnd;
                end else begin
                    // ALU ops carry no operand; bus values are valid alongside en.
                    cb_d    = ir_q;
                    ac_d    = '0;
                    state_d = StExec;
                end
            end
            StOpnd: begin
                if (is_jump) begin
                    icnt_d = icnt_inc;
                    if (ir_q == OP_JZ && stk_top != '0) begin
                        pc_d = pc_q + ADDR_LEN'(2);
                    end else begin
                        pc_d = ADDR_LEN'(imem_data);
                    end
                    state_d = StFetch;
                end else begin
                    cb_d    = ir_q;
                    ac_d    = imem_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                wcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // Only the unit that was dispatched may complete the instruction.
                if ((is_pp && pp_fin) || (is_alu && alu_fin)) begin
                    pc_d    = pc_q + ADDR_LEN'(instr_len(ir_q));
                    icnt_d  = icnt_inc;
                    state_d = StFetch;
                end else if (wcnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    wcnt_d = wcnt_q + CntW'(1);
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            ir_q    <= '0;
            pc_q    <= '0;
            cb_q    <= '0;
            ac_q    <= '0;
            icnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            cb_q    <= cb_d;
            ac_q    <= ac_d;
            icnt_q  <= icnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign imem_addr   = (state_q == StOpnd) ? pc_q + ADDR_LEN'(1) : pc_q;
    assign pp_en       = (state_q == StExec) && is_pp;
    assign alu_en      = (state_q == StExec) && is_alu;
    assign control_bus = cb_q;
    assign addr_const  = ac_q;
    assign pc          = pc_q;
    assign busy        = !(state_q == StIdle || state_q == StHalt || state_q == StError);
    assign halted      = (state_q == StHalt);
    assign err         = (state_q == StError);
    assign instr_cnt   = icnt_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  imem_addr, imem_data, stk_top;
    logic        pp_en, pp_fin, alu_en, alu_fin;
    logic [3:0]  control_bus;
    logic [7:0]  addr_const, pc;
    logic        busy, halted, err;
    logic [15:0] instr_cnt;

    logic [7:0] mem [256];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    stack_sequencer #(.ADDR_LEN(8), .DATA_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stk_top     (stk_top),
        .pp_en       (pp_en),
        .pp_fin      (pp_fin),
        .alu_en      (alu_en),
        .alu_fin     (alu_fin),
        .control_bus (control_bus),
        .addr_const  (addr_const),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_cnt   (instr_cnt)
    );

    // Unit models: fin two cycles after en, or forced by hand.
    logic       pp_auto, alu_auto, pp_force, alu_force;
    logic [3:0] pp_sh, alu_sh;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pp_sh  <= '0;
            alu_sh <= '0;
        end else begin
            pp_sh  <= {pp_sh[2:0], pp_en};
            alu_sh <= {alu_sh[2:0], alu_en};
        end
    end
    assign pp_fin  = (pp_auto && pp_sh[1]) || pp_force;
    assign alu_fin = (alu_auto && alu_sh[1]) || alu_force;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected enable pulses: {is_alu, opcode, operand}.
    typedef struct packed {
        logic       is_alu;
        logic [3:0] op;
        logic [7:0] addr;
    } pulse_t;
    pulse_t exp_q[$];

    always @(negedge clk) begin
        if (rstn && (pp_en || alu_en)) begin
            total++;
            if (pp_en && alu_en) begin
                bad++;
                $display("FAIL both_en: got pp_en=1 alu_en=1 expected one");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got alu=%0b op=%0h addr=%0h expected none",
                         alu_en, control_bus, addr_const);
            end else begin
                pulse_t e;
                pulse_t a;
                e = exp_q.pop_front();
                a = '{is_alu: alu_en, op: control_bus, addr: addr_const};
                if (a !== e) begin
                    bad++;
                    $display("FAIL pulse: got %0h expected %0h", a, e);
                end
            end
        end
    end

    // ISA-level reference walk of mem: pushes the pulses the program should make.
    task automatic model_run(input logic [7:0] stk);
        logic [7:0] p;
        logic [7:0] w;
        logic [3:0] op;
        p = 8'h00;
        for (int s = 0; s < 64; s++) begin
            w  = mem[p];
            op = w[3:0];
            if (op <= 4'd2) begin
                exp_q.push_back('{is_alu: 1'b0, op: op, addr: mem[p + 8'd1]});
                p = p + 8'd2;
            end else if (op >= 4'd4 && op <= 4'd7) begin
                exp_q.push_back('{is_alu: 1'b1, op: op, addr: 8'h00});
                p = p + 8'd1;
            end else if (op == 4'd8) begin
                p = mem[p + 8'd1];
            end else if (op == 4'd9) begin
                p = (stk == 8'h00) ? mem[p + 8'd1] : p + 8'd2;
            end else begin
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        pp_force  = 1'b0;
        alu_force = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h0F;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            if (halted || err) return;
            @(negedge clk);
        end
        check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_en(input bit alu, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((alu && alu_en) || (!alu && pp_en)) return;
        end
        check({name, "_en_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [47:0] prog;
        logic [7:0]  stk;
        logic [7:0]  exp_pc;
        logic        exp_halted;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{48'h00_05_00_07_04_0F, 8'h00, 8'h05, 1'b1, 1'b0, 16'd4};
        vecs[1] = '{48'h09_20_0F_0F_0F_0F, 8'h00, 8'h20, 1'b1, 1'b0, 16'd2};
        vecs[2] = '{48'h09_20_0F_0F_0F_0F, 8'h03, 8'h02, 1'b1, 1'b0, 16'd2};
        vecs[3] = '{48'h08_10_0F_0F_0F_0F, 8'h00, 8'h10, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{48'h04_05_06_0B_0F_0F, 8'h00, 8'h03, 1'b0, 1'b1, 16'd3};
        vecs[5] = '{48'h0F_0F_0F_0F_0F_0F, 8'h00, 8'h00, 1'b1, 1'b0, 16'd1};
        vecs[6] = '{48'h02_AA_07_0F_0F_0F, 8'h00, 8'h03, 1'b1, 1'b0, 16'd3};
        vecs[7] = '{48'h03_0F_0F_0F_0F_0F, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0};
        vecs[8] = '{48'h0E_0F_0F_0F_0F_0F, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0};
        vecs[9] = '{48'h01_C4_09_00_0F_0F, 8'h05, 8'h04, 1'b1, 1'b0, 16'd3};

        rstn = 1'b0; start = 1'b0; stk_top = 8'h00;
        pp_auto = 1'b1; alu_auto = 1'b1; pp_force = 1'b0; alu_force = 1'b0;
        fill_mem();
        #1;
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_flags", {busy, halted, err, pp_en, alu_en}, 32'd0);
        check("rst_bus", {20'd0, control_bus, addr_const}, 32'd0);
        check("rst_cnt", {16'd0, instr_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Table-driven programs.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            fill_mem();
            for (int i = 0; i < 6; i++) mem[i] = vecs[v].prog[47 - 8*i -: 8];
            stk_top = vecs[v].stk;
            model_run(vecs[v].stk);
            pulse_start();
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_pc", v), {24'd0, pc}, {24'd0, vecs[v].exp_pc});
            check($sformatf("v%0d_halted", v), {31'd0, halted}, {31'd0, vecs[v].exp_halted});
            check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d_cnt", v), {16'd0, instr_cnt}, {16'd0, vecs[v].exp_cnt});
            check($sformatf("v%0d_pulses_left", v), exp_q.size(), 32'd0);
            exp_q.delete();
        end

        // Timeout: push/pop unit never answers.
        do_reset();
        fill_mem();
        mem[0] = 8'h01; mem[1] = 8'h33;
        pp_auto = 1'b0;
        exp_q.push_back('{is_alu: 1'b0, op: 4'h1, addr: 8'h33});
        pulse_start();
        wait_en(1'b0, "to");
        repeat (TIMEOUT) @(negedge clk);
        check("to_not_yet", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_pc", {24'd0, pc}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("to_sticky", {30'd0, err, pp_en}, 32'd2);
        end
        check("to_pulses_left", exp_q.size(), 32'd0);
        exp_q.delete();

        // Stray alu_fin (and start) while waiting on push/pop.
        do_reset();
        fill_mem();
        mem[0] = 8'h00; mem[1] = 8'h44;
        pp_auto = 1'b0; alu_auto = 1'b0;
        exp_q.push_back('{is_alu: 1'b0, op: 4'h0, addr: 8'h44});
        pulse_start();
        wait_en(1'b0, "stray");
        alu_force = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        alu_force = 1'b0; start = 1'b0;
        @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd1);
        check("stray_pc", {24'd0, pc}, 32'd0);
        pp_force = 1'b1;
        @(negedge clk);
        pp_force = 1'b0;
        check("stray_pc_adv", {24'd0, pc}, 32'd2);
        wait_done("stray");
        check("stray_halt", {30'd0, halted, err}, 32'd2);
        check("stray_cnt", {16'd0, instr_cnt}, 32'd2);
        check("stray_pulses_left", exp_q.size(), 32'd0);
        exp_q.delete();
        alu_auto = 1'b1;

        // Asynchronous reset in the middle of a WAIT.
        do_reset();
        fill_mem();
        mem[0] = 8'h04; mem[1] = 8'h01; mem[2] = 8'h12;
        exp_q.push_back('{is_alu: 1'b1, op: 4'h4, addr: 8'h00});
        exp_q.push_back('{is_alu: 1'b0, op: 4'h1, addr: 8'h12});
        pulse_start();
        wait_en(1'b0, "rst");
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_pc", {24'd0, pc}, 32'd0);
        check("rst_mid_cnt", {16'd0, instr_cnt}, 32'd0);
        check("rst_mid_bus", {20'd0, control_bus, addr_const}, 32'd0);
        check("rst_mid_flags", {busy, halted, err, pp_en, alu_en}, 32'd0);
        check("rst_mid_pulses_left", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        pp_auto = 1'b1;
        fill_mem();
        mem[0] = 8'h04;
        exp_q.push_back('{is_alu: 1'b1, op: 4'h4, addr: 8'h00});
        pulse_start();
        wait_done("rerun");
        check("rerun_halt", {30'd0, halted, err}, 32'd2);
        check("rerun_pc", {24'd0, pc}, 32'd1);
        check("rerun_cnt", {16'd0, instr_cnt}, 32'd2);
        check("rerun_pulses_left", exp_q.size(), 32'd0);
        exp_q.delete();

        // JMP to 0xFF then a 1-word ALU op wraps pc to 0x00.
        do_reset();
        fill_mem();
        mem[0] = 8'h08; mem[1] = 8'hFF; mem[255] = 8'h04;
        exp_q.push_back('{is_alu: 1'b1, op: 4'h4, addr: 8'h00});
        pulse_start();
        wait_en(1'b1, "wrap");
        check("wrap_pc_ff", {24'd0, pc}, 32'hFF);
        repeat (2) @(negedge clk);
        check("wrap_pc_hold", {24'd0, pc}, 32'hFF);
        @(negedge clk);
        check("wrap_pc_0", {24'd0, pc}, 32'h00);
        check("wrap_cnt", {16'd0, instr_cnt}, 32'd2);
        check("wrap_pulses_left", exp_q.size(), 32'd0);
        exp_q.delete();
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
